// File: rtl/sd_pkg.sv
// Shared types and constants for the serial feeder, the "0001" detector and their bench.
package sd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic       IDLE_BIT_DEFAULT = 1'b1;
  localparam logic [3:0] DETECT_PATTERN   = 4'b0001;

endpackage

// File: rtl/sd_bit_counter.sv
// Loadable down-counter with enable and zero flag; saturates at zero rather than wrapping.
module sd_bit_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sd_serial_feeder.sv
// Parallel-in/serial-out feeder driving the serial input of the "0001" detector,
// holding x at an idle level between words and streaming back-to-back words gaplessly.
module sd_serial_feeder
  import sd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             ready_en;
  logic             accept;
  logic             cnt_en;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // ready_en keeps din_ready low until the first clock after reset release
  always_comb begin
    din_ready = ready_en &&
                ((state == IDLE) || ((state == SHIFT) && cnt_zero && bit_en));
    accept    = din_valid && din_ready;
    cnt_en    = (state == SHIFT) && bit_en;
    sreg_next = advance(sreg);
  end

  sd_bit_counter #(
    .WIDTH (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .en       (cnt_en),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      x        <= IDLE_BIT;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            sreg    <= din;
            x       <= head_bit(din);
            x_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (cnt_zero) begin
              done <= 1'b1;
              if (accept) begin
                sreg <= din;
                x    <= head_bit(din);
              end else begin
                state   <= IDLE;
                x       <= IDLE_BIT;
                x_valid <= 1'b0;
                busy    <= 1'b0;
              end
            end else begin
              sreg <= sreg_next;
              x    <= head_bit(sreg_next);
            end
          end
        end
        default: begin
          state   <= IDLE;
          x       <= IDLE_BIT;
          x_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_serial_feeder.md
Name: sd_serial_feeder

Overview:
Parallel-in/serial-out feeder that sits directly upstream of the "0001" sequence detector and drives its serial input x.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out one bit per enabled clock, MSB-first or LSB-first.
- Holds x at a safe idle level between words, so the detector never sees a spurious run of zeros.

Parameters:
WIDTH, 8, word width in bits (2..32)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_BIT, 1'b1, level driven on x when no word is being shifted (1 avoids false "000" runs)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
din  input  WIDTH  parallel word to serialise
din_valid  input  1  din holds a word to load
din_ready  output  1  feeder can accept a word this cycle
bit_en  input  1  shift-rate tick; one bit advances per cycle with bit_en=1
x  output  1  serial bit to detector
x_valid  output  1  x carries a data bit (0 = idle fill)
busy  output  1  a word is in progress
done  output  1  one-cycle pulse on the edge after the last bit of a word has been held

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register=0; bit counter=0.
  - x=IDLE_BIT, x_valid=0, busy=0, done=0, din_ready=0.
  - din_ready rises on the first clock after rst deasserts.
- All outputs are registered except din_ready. din_ready is combinational from state, counter and bit_en.
- States:
  - IDLE: din_ready=1. On valid&&ready, load din into the shift register, counter=WIDTH-1, go to SHIFT. On the next cycle x=first bit and x_valid=1.
  - SHIFT: x holds the current bit until a cycle with bit_en=1. On that edge, advance to the next bit (shift by 1 per MSB_FIRST) and decrement the counter.
- Last bit (counter=0, bit_en=1), one of two cases:
  - If din_valid=1 that cycle: load the new word, stay in SHIFT, set done=1. The first bit of the new word appears next cycle with no idle gap.
  - Otherwise: go to IDLE, set x=IDLE_BIT, x_valid=0, done=1.
- din_ready = (state==IDLE) || (state==SHIFT && counter==0 && bit_en). This gives gapless back-to-back streaming.
- bit_en ignored in IDLE. A load does not wait for bit_en; the first bit is held at least one cycle.
- busy = (state==SHIFT).
- din_valid is sampled only when din_ready=1. din may change freely otherwise.
- Counter width is $clog2(WIDTH). No wrap: the counter only decrements from WIDTH-1 to 0.
- Reset mid-word aborts immediately. x returns to IDLE_BIT asynchronously, and the partial word is discarded with no done pulse.
- x never glitches to a non-idle value while x_valid=0.

Decomposition:
- Shared package sd_pkg holds:
  - state typedef (IDLE, SHIFT);
  - IDLE_BIT default;
  - the detector pattern constant 4'b0001, shared with the detector stage and the bench.
- One natural sub-module: sd_bit_counter, a loadable down-counter with a zero flag and enable. The FSM and shift register stay in the top module.

Test Plan:
1. Reset: hold rst=0 for 3 clocks with din_valid=1 -> x=1, x_valid=0, busy=0, din_ready=0. One clock after release -> din_ready=1.
2. MSB-first word: WIDTH=8, bit_en=1 always, din=8'hE1 -> x=1,1,1,0,0,0,0,1 on 8 consecutive cycles with x_valid=1. done pulses once; then x=1, x_valid=0. The downstream detector sees 0001 and asserts y once.
3. LSB-first (MSB_FIRST=0), din=8'h87, bit_en every 3rd cycle -> each bit held exactly 3 cycles. Order is 1,1,1,0,0,0,0,1. 24 data cycles total.
4. Back-to-back: din_valid held with 8'h0F then 8'hF0 -> 16 contiguous x_valid cycles (0000111111110000). done pulses after bit 8 and after bit 16. No idle bit between words.
5. Mid-word reset: load 8'h00, assert rst=0 after 3 bits -> x=1 and x_valid=0 immediately, no done pulse. After release, a new word 8'hAA shifts 1,0,1,0,1,0,1,0 correctly.
6. Backpressure: din_valid=1 during SHIFT with counter>0 -> din_ready=0 and din not loaded. Change din mid-word -> the in-flight bits are unaffected.
